// File: rtl/apb_requester_if.sv
// Command, response and APB bundle for the APB requester.
// The master modport is the requester's view; slave is the view of whatever surrounds it.
interface apb_requester_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_timeout;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_requester.sv
// APB initiator: turns one valid/ready command into a SETUP/ACCESS transfer and
// returns its completion (or a wait-state timeout) on the response stream.
module apb_requester #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    apb_requester_if.master  bus
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    always_comb bus.cmd_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.pwrite      <= 1'b0;
            bus.paddr       <= '0;
            bus.pwdata      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.pwrite <= bus.cmd_write;
                        bus.paddr  <= bus.cmd_addr;
                        bus.pwdata <= bus.cmd_wdata;
                        bus.psel   <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // pready takes precedence over a timeout landing on the same edge
                    if (bus.pready) begin
                        bus.rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.psel        <= 1'b0;
                        bus.penable     <= 1'b0;
                        state           <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && wait_cnt == LIMIT) begin
                        bus.rsp_rdata   <= '0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        bus.psel        <= 1'b0;
                        bus.penable     <= 1'b0;
                        state           <= RESP;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a short wait-state timeout (4 cycles).
module tb_apb_requester;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_requester #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_wdata[4];
    logic        b2b_write[4];
    logic [31:0] b2b_prd  [4];

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0; bus.pready = 1'b0; bus.prdata = '0;
        repeat (2) @(negedge clk);
        if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_timeout, bus.cmd_ready} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=000000",
                {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_timeout, bus.cmd_ready});
        end
        total++;
        if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {bus.paddr, bus.pwdata, bus.rsp_rdata});
        end
        total++;
        rst = 1'b0;
        #1;
        if (bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_cmd_ready got=%b exp=1", bus.cmd_ready);
        end
        total++;
    endtask

    task automatic test_write_nowait();
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
        bus.cmd_addr = 32'h0000_0010; bus.cmd_wdata = 32'hDEAD_BEEF;
        bus.pready = 1'b1; bus.rsp_ready = 1'b1; bus.prdata = 32'h7777_7777;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_addr = 32'hFFFF_FFFF; bus.cmd_wdata = '0;
        if ({bus.psel, bus.penable, bus.pwrite} !== 3'b101) begin
            bad++; $display("FAIL wr_setup got=%b exp=101", {bus.psel, bus.penable, bus.pwrite});
        end
        total++;
        if (bus.paddr !== 32'h10 || bus.pwdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL wr_setup_bus got=%h/%h exp=10/deadbeef", bus.paddr, bus.pwdata);
        end
        total++;
        @(negedge clk);
        if ({bus.psel, bus.penable} !== 2'b11 || bus.paddr !== 32'h10 || bus.pwdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL wr_access got=%b %h %h exp=11 10 deadbeef",
                {bus.psel, bus.penable}, bus.paddr, bus.pwdata);
        end
        total++;
        @(negedge clk);
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_timeout} !== 4'b0010 || bus.rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL wr_rsp got=%b rdata=%h exp=0010 rdata=0",
                {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_timeout}, bus.rsp_rdata);
        end
        total++;
        if (bus.paddr !== 32'h10) begin
            bad++; $display("FAIL wr_paddr_retained got=%h exp=10", bus.paddr);
        end
        total++;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL wr_idle got=%b%b exp=01", bus.rsp_valid, bus.cmd_ready);
        end
        total++;
    endtask

    task automatic test_read_wait();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0104;
        bus.pready = 1'b0; bus.rsp_ready = 1'b1; bus.prdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (bus.cmd_ready !== 1'b0 || {bus.psel, bus.penable} !== 2'b10) begin
            bad++; $display("FAIL rd_setup got=%b%b%b exp=010", bus.cmd_ready, bus.psel, bus.penable);
        end
        total++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid} !== 4'b1100 || bus.paddr !== 32'h104) begin
                bad++; $display("FAIL rd_access%0d got=%b %h exp=1100 104", i,
                    {bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid}, bus.paddr);
            end
            total++;
            if (i == 3) begin
                bus.pready = 1'b1; bus.prdata = 32'h1234_5678;
            end
        end
        @(negedge clk);
        bus.pready = 1'b0; bus.prdata = 32'hBAD0_BAD0;
        if ({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout} !== 5'b00010 ||
            bus.rsp_rdata !== 32'h1234_5678) begin
            bad++; $display("FAIL rd_rsp got=%b rdata=%h exp=00010 rdata=12345678",
                {bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout}, bus.rsp_rdata);
        end
        total++;
        @(negedge clk);
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rd_idle got=%b%b exp=10", bus.cmd_ready, bus.rsp_valid);
        end
        total++;
    endtask

    task automatic test_timeout();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0200;
        bus.pready = 1'b0; bus.rsp_ready = 1'b1; bus.prdata = 32'hFACE_FACE;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({bus.psel, bus.penable} !== 2'b11) begin
                bad++; $display("FAIL to_access%0d got=%b exp=11", i, {bus.psel, bus.penable});
            end
            total++;
        end
        @(negedge clk);
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_timeout} !== 4'b0011 || bus.rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL to_rsp got=%b rdata=%h exp=0011 rdata=0",
                {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_timeout}, bus.rsp_rdata);
        end
        total++;
        @(negedge clk);
        if (bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL to_idle got=%b exp=1", bus.cmd_ready);
        end
        total++;

        // same limit, but pready rises in the 4th ACCESS cycle
        bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h0000_0204;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bus.pready = 1'b1; bus.prdata = 32'hCAFE_F00D;
            end
        end
        @(negedge clk);
        bus.pready = 1'b0;
        if ({bus.rsp_valid, bus.rsp_timeout} !== 2'b10 || bus.rsp_rdata !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL to_edge_rsp got=%b rdata=%h exp=10 rdata=cafef00d",
                {bus.rsp_valid, bus.rsp_timeout}, bus.rsp_rdata);
        end
        total++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0300; bus.cmd_wdata = '0;
        bus.pready = 1'b1; bus.rsp_ready = 1'b0; bus.prdata = 32'hA5A5_5A5A;
        @(negedge clk);
        bus.cmd_write = 1'b1; bus.cmd_addr = 32'h0000_0400; bus.cmd_wdata = 32'h0000_0055;
        @(negedge clk);
        @(negedge clk);
        bus.prdata = 32'h0BAD_0BAD;
        for (int k = 0; k < 5; k++) begin
            if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 3'b100 || bus.rsp_rdata !== 32'hA5A5_5A5A ||
                bus.paddr !== 32'h300) begin
                bad++; $display("FAIL bp_hold%0d got=%b rdata=%h paddr=%h exp=100 a5a55a5a 300", k,
                    {bus.rsp_valid, bus.cmd_ready, bus.psel}, bus.rsp_rdata, bus.paddr);
            end
            total++;
            if (k == 4) bus.rsp_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        if ({bus.cmd_ready, bus.psel, bus.rsp_valid} !== 3'b100) begin
            bad++; $display("FAIL bp_idle got=%b exp=100", {bus.cmd_ready, bus.psel, bus.rsp_valid});
        end
        total++;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (bus.psel !== 1'b1 || bus.paddr !== 32'h400 || bus.pwrite !== 1'b1 || bus.pwdata !== 32'h55) begin
            bad++; $display("FAIL bp_second got=%b %h %b %h exp=1 400 1 55",
                bus.psel, bus.paddr, bus.pwrite, bus.pwdata);
        end
        total++;
        @(negedge clk);
        @(negedge clk);
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL bp_second_rsp got=%b rdata=%h exp=1 rdata=0", bus.rsp_valid, bus.rsp_rdata);
        end
        total++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int pulses;
        int j;
        int phase;
        logic psel_prev;
        pulses = 0;
        psel_prev = 1'b0;
        bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1; bus.pready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            if (c >= 1) begin
                phase = (c - 1) % 4;
                j = (c - 1) / 4;
                if (bus.psel && !psel_prev) pulses++;
                psel_prev = bus.psel;
                case (phase)
                    0: begin
                        if ({bus.psel, bus.penable} !== 2'b10 || bus.paddr !== b2b_addr[j] ||
                            bus.pwrite !== b2b_write[j]) begin
                            bad++; $display("FAIL b2b_setup%0d got=%b %h %b exp=10 %h %b", j,
                                {bus.psel, bus.penable}, bus.paddr, bus.pwrite, b2b_addr[j], b2b_write[j]);
                        end
                        total++;
                    end
                    1: begin
                        if ({bus.psel, bus.penable} !== 2'b11) begin
                            bad++; $display("FAIL b2b_access%0d got=%b exp=11", j, {bus.psel, bus.penable});
                        end
                        total++;
                    end
                    2: begin
                        if (bus.psel !== 1'b0 || bus.rsp_valid !== 1'b1 ||
                            bus.rsp_rdata !== (b2b_write[j] ? 32'h0 : b2b_prd[j])) begin
                            bad++; $display("FAIL b2b_rsp%0d got=%b%b rdata=%h exp=01 rdata=%h", j,
                                bus.psel, bus.rsp_valid, bus.rsp_rdata, b2b_write[j] ? 32'h0 : b2b_prd[j]);
                        end
                        total++;
                    end
                    default: begin
                        if ({bus.psel, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
                            bad++; $display("FAIL b2b_idle%0d got=%b exp=001", j,
                                {bus.psel, bus.rsp_valid, bus.cmd_ready});
                        end
                        total++;
                    end
                endcase
            end
            if (c % 4 == 0 && c < 16) begin
                bus.cmd_write = b2b_write[c / 4];
                bus.cmd_addr  = b2b_addr[c / 4];
                bus.cmd_wdata = b2b_wdata[c / 4];
                bus.prdata    = b2b_prd[c / 4];
            end
            if (c == 13) bus.cmd_valid = 1'b0;
            @(negedge clk);
        end
        if (pulses != 4) begin
            bad++; $display("FAIL b2b_pulses got=%0d exp=4", pulses);
        end
        total++;
    endtask

    task automatic test_reset_mid();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0500;
        bus.pready = 1'b0; bus.rsp_ready = 1'b1; bus.prdata = 32'h9999_9999;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        if (bus.penable !== 1'b1) begin
            bad++; $display("FAIL rm_pre got=%b exp=1", bus.penable);
        end
        total++;
        #2 rst = 1'b1;
        #1;
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin
            bad++; $display("FAIL rm_async got=%b exp=0000",
                {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
        end
        total++;
        bus.pready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({bus.psel, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
                bad++; $display("FAIL rm_after%0d got=%b exp=001", i,
                    {bus.psel, bus.rsp_valid, bus.cmd_ready});
            end
            total++;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        b2b_write[0] = 1'b1; b2b_addr[0] = 32'h0000_1000; b2b_wdata[0] = 32'h1111_1111; b2b_prd[0] = 32'hFFFF_0000;
        b2b_write[1] = 1'b0; b2b_addr[1] = 32'h0000_1004; b2b_wdata[1] = 32'h0;         b2b_prd[1] = 32'h2222_2222;
        b2b_write[2] = 1'b1; b2b_addr[2] = 32'h0000_1008; b2b_wdata[2] = 32'h3333_3333; b2b_prd[2] = 32'hFFFF_0001;
        b2b_write[3] = 1'b0; b2b_addr[3] = 32'h0000_100C; b2b_wdata[3] = 32'h0;         b2b_prd[3] = 32'h4444_4444;
        test_reset();
        test_write_nowait();
        test_read_wait();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
